// File: rtl/pe_elastic_relay.sv
// pe_elastic_relay: four independent elastic FIFO relays (east/west/north/south) sharing one ap_start gate.

module pe_relay_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ap_start,
    input  logic [W-1:0]     i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [W-1:0]     o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [CNT_W-1:0] o_occ
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CNT_W-1:0] r_cnt;
    logic             w_push;
    logic             w_pop;

    // Reset gates the handshakes combinationally so ready cannot rise while reset is held.
    always_comb begin
        o_ready = ap_start && !reset && (r_cnt != FULL);
        o_valid = ap_start && !reset && (r_cnt != '0);
        o_data  = (r_cnt != '0) ? r_mem[r_rd] : '0;
        o_occ   = r_cnt;
        w_push  = i_valid && o_ready;
        w_pop   = o_valid && i_ready;
    end

    // DEPTH is a power of two, so pointers wrap naturally at DEPTH-1 -> 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end
endmodule

module pe_elastic_relay #(
    parameter int EAST_WIDTH  = 134,
    parameter int WEST_WIDTH  = 130,
    parameter int NORTH_WIDTH = 130,
    parameter int SOUTH_WIDTH = 200,
    parameter int DEPTH       = 4,
    parameter int CNT_W       = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ap_start,
    input  logic [EAST_WIDTH-1:0]  in_from_east,
    input  logic                   in_from_east_valid,
    output logic                   in_from_east_ready,
    output logic [EAST_WIDTH-1:0]  out_to_east,
    output logic                   out_to_east_valid,
    input  logic                   out_to_east_ready,
    output logic [CNT_W-1:0]       occ_east,
    input  logic [WEST_WIDTH-1:0]  in_from_west,
    input  logic                   in_from_west_valid,
    output logic                   in_from_west_ready,
    output logic [WEST_WIDTH-1:0]  out_to_west,
    output logic                   out_to_west_valid,
    input  logic                   out_to_west_ready,
    output logic [CNT_W-1:0]       occ_west,
    input  logic [NORTH_WIDTH-1:0] in_from_north,
    input  logic                   in_from_north_valid,
    output logic                   in_from_north_ready,
    output logic [NORTH_WIDTH-1:0] out_to_north,
    output logic                   out_to_north_valid,
    input  logic                   out_to_north_ready,
    output logic [CNT_W-1:0]       occ_north,
    input  logic [SOUTH_WIDTH-1:0] in_from_south,
    input  logic                   in_from_south_valid,
    output logic                   in_from_south_ready,
    output logic [SOUTH_WIDTH-1:0] out_to_south,
    output logic                   out_to_south_valid,
    input  logic                   out_to_south_ready,
    output logic [CNT_W-1:0]       occ_south
);
    pe_relay_fifo #(.W(EAST_WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_east (
        .clk(clk), .reset(reset), .ap_start(ap_start),
        .i_data(in_from_east), .i_valid(in_from_east_valid), .o_ready(in_from_east_ready),
        .o_data(out_to_east), .o_valid(out_to_east_valid), .i_ready(out_to_east_ready),
        .o_occ(occ_east)
    );

    pe_relay_fifo #(.W(WEST_WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_west (
        .clk(clk), .reset(reset), .ap_start(ap_start),
        .i_data(in_from_west), .i_valid(in_from_west_valid), .o_ready(in_from_west_ready),
        .o_data(out_to_west), .o_valid(out_to_west_valid), .i_ready(out_to_west_ready),
        .o_occ(occ_west)
    );

    pe_relay_fifo #(.W(NORTH_WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_north (
        .clk(clk), .reset(reset), .ap_start(ap_start),
        .i_data(in_from_north), .i_valid(in_from_north_valid), .o_ready(in_from_north_ready),
        .o_data(out_to_north), .o_valid(out_to_north_valid), .i_ready(out_to_north_ready),
        .o_occ(occ_north)
    );

    pe_relay_fifo #(.W(SOUTH_WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_south (
        .clk(clk), .reset(reset), .ap_start(ap_start),
        .i_data(in_from_south), .i_valid(in_from_south_valid), .o_ready(in_from_south_ready),
        .o_data(out_to_south), .o_valid(out_to_south_valid), .i_ready(out_to_south_ready),
        .o_occ(occ_south)
    );
endmodule
